// File: rtl/cpu_pkg.sv
// Shared constants for the single-bus CPU: opcodes, ALU op codes, sequencer states
// and instruction classes.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BRX  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU codes reuse the register-form opcode values
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    typedef logic [3:0] state_t;
    localparam state_t S_RESET = 4'd0;
    localparam state_t S_T0    = 4'd1;
    localparam state_t S_T1    = 4'd2;
    localparam state_t S_T2    = 4'd3;
    localparam state_t S_T3    = 4'd4;
    localparam state_t S_T4    = 4'd5;
    localparam state_t S_T5    = 4'd6;
    localparam state_t S_T6    = 4'd7;
    localparam state_t S_T7    = 4'd8;
    localparam state_t S_HALT  = 4'd9;

    typedef enum logic [2:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LDI,
        CLS_LD,
        CLS_ST,
        CLS_BR,
        CLS_NOP,
        CLS_HALT
    } op_class_t;

    // ALU operation selected by an ALU-class opcode (register or immediate form)
    function automatic logic [4:0] alu_for_op(input logic [4:0] opcode);
        case (opcode)
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR, OP_ORI:   return ALU_OR;
            default:         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit bus: IR and status inputs plus every strobe towards the datapath,
// select/encode stage and memory.
interface control_unit_if;
    logic [31:0] IR;
    logic        CON;
    logic        mem_done;
    logic        Gra, Grb, Grc;
    logic        Rin, Rout, BAout;
    logic        PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout;
    logic        Yin, Zin, Zlowout, Cout, CONin;
    logic        Read, Write;
    logic [4:0]  alu_op;
    logic        run;

    modport master (
        input  IR, CON, mem_done,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
        output Yin, Zin, Zlowout, Cout, CONin, Read, Write, alu_op, run
    );

    modport slave (
        output IR, CON, mem_done,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
        input  Yin, Zin, Zlowout, Cout, CONin, Read, Write, alu_op, run
    );
endinterface

// File: rtl/opcode_class.sv
// Maps the 5-bit opcode onto the instruction class that picks the micro-state path.
module opcode_class
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    // Undefined opcodes fall into the nop class
    always_comb begin
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = CLS_ALU_R;
            OP_ADDI, OP_ANDI, OP_ORI:      op_class = CLS_ALU_I;
            OP_LDI:                        op_class = CLS_LDI;
            OP_LD:                         op_class = CLS_LD;
            OP_ST:                         op_class = CLS_ST;
            OP_BRX:                        op_class = CLS_BR;
            OP_HALT:                       op_class = CLS_HALT;
            OP_NOP:                        op_class = CLS_NOP;
            default:                       op_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer: fetch (T0-T2), then per-class execute states T3-T7.
// Outputs are decoded from the registered state and the current IR opcode.
module control_unit
    import cpu_pkg::*;
(
    input logic             clk,
    input logic             clear,
    control_unit_if.master  bus
);

    state_t     state, state_next;
    op_class_t  op_class;
    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = bus.IR[31:27];
    // Operand fields are consumed by the select/encode stage, not here
    assign unused_ir = ^bus.IR[26:0];

    opcode_class u_opcode_class (
        .opcode   (opcode),
        .op_class (op_class)
    );

    // State register with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clear) state <= S_RESET;
        else        state <= state_next;
    end

    // Next-state sequencing; mem_done only matters in the three wait states
    always_comb begin
        state_next = state;
        case (state)
            S_RESET: state_next = S_T0;
            S_T0:    state_next = S_T1;
            S_T1:    if (bus.mem_done) state_next = S_T2;
            S_T2:    state_next = S_T3;
            S_T3: begin
                if (op_class == CLS_HALT)     state_next = S_HALT;
                else if (op_class == CLS_NOP) state_next = S_T0;
                else                          state_next = S_T4;
            end
            S_T4:    state_next = S_T5;
            S_T5: begin
                if (op_class == CLS_LD || op_class == CLS_ST || op_class == CLS_BR)
                    state_next = S_T6;
                else
                    state_next = S_T0;
            end
            S_T6: begin
                if (op_class == CLS_ST)                      state_next = S_T7;
                else if (op_class == CLS_LD)                 state_next = bus.mem_done ? S_T7 : S_T6;
                else                                         state_next = S_T0;
            end
            S_T7:    if (op_class != CLS_ST || bus.mem_done) state_next = S_T0;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    // Moore strobe decode; everything defaults low
    always_comb begin
        bus.Gra = 1'b0;     bus.Grb = 1'b0;     bus.Grc = 1'b0;
        bus.Rin = 1'b0;     bus.Rout = 1'b0;    bus.BAout = 1'b0;
        bus.PCout = 1'b0;   bus.PCin = 1'b0;    bus.IncPC = 1'b0;
        bus.IRin = 1'b0;    bus.MARin = 1'b0;   bus.MDRin = 1'b0;
        bus.MDRout = 1'b0;  bus.Yin = 1'b0;     bus.Zin = 1'b0;
        bus.Zlowout = 1'b0; bus.Cout = 1'b0;    bus.CONin = 1'b0;
        bus.Read = 1'b0;    bus.Write = 1'b0;   bus.alu_op = 5'd0;
        bus.run = 1'b1;
        case (state)
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    CLS_ALU_R, CLS_ALU_I: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                    end
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                    end
                    CLS_BR: begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (op_class)
                    CLS_ALU_R: begin
                        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
                        bus.alu_op = alu_for_op(opcode);
                    end
                    CLS_ALU_I: begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = alu_for_op(opcode);
                    end
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = ALU_ADD;
                    end
                    CLS_BR: begin
                        bus.PCout = 1'b1; bus.Yin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_class)
                    CLS_ALU_R, CLS_ALU_I, CLS_LDI: begin
                        bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        bus.Zlowout = 1'b1; bus.MARin = 1'b1;
                    end
                    CLS_BR: begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op_class)
                    CLS_LD: begin
                        bus.Read = 1'b1; bus.MDRin = 1'b1;
                    end
                    CLS_ST: begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
                    end
                    CLS_BR: begin
                        bus.Zlowout = bus.CON; bus.PCin = bus.CON;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op_class)
                    CLS_LD: begin
                        bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    end
                    CLS_ST:  bus.Write = 1'b1;
                    default: ;
                endcase
            end
            default: bus.run = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: table of instructions run with zero-wait memory, then
// hand-written sequences for reset, memory waits, ignored mem_done and halt.
module tb_control_unit;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    control_unit_if bus ();

    control_unit dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    localparam logic [20:0] M_GRA    = 21'h100000;
    localparam logic [20:0] M_GRB    = 21'h080000;
    localparam logic [20:0] M_GRC    = 21'h040000;
    localparam logic [20:0] M_RIN    = 21'h020000;
    localparam logic [20:0] M_ROUT   = 21'h010000;
    localparam logic [20:0] M_BAOUT  = 21'h008000;
    localparam logic [20:0] M_PCOUT  = 21'h004000;
    localparam logic [20:0] M_PCIN   = 21'h002000;
    localparam logic [20:0] M_INCPC  = 21'h001000;
    localparam logic [20:0] M_IRIN   = 21'h000800;
    localparam logic [20:0] M_MARIN  = 21'h000400;
    localparam logic [20:0] M_MDRIN  = 21'h000200;
    localparam logic [20:0] M_MDROUT = 21'h000100;
    localparam logic [20:0] M_YIN    = 21'h000080;
    localparam logic [20:0] M_ZIN    = 21'h000040;
    localparam logic [20:0] M_ZLOW   = 21'h000020;
    localparam logic [20:0] M_COUT   = 21'h000010;
    localparam logic [20:0] M_CONIN  = 21'h000008;
    localparam logic [20:0] M_READ   = 21'h000004;
    localparam logic [20:0] M_WRITE  = 21'h000002;
    localparam logic [20:0] M_RUN    = 21'h000001;

    localparam logic [20:0] W_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [20:0] W_T1 = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
    localparam logic [20:0] W_T2 = M_MDROUT | M_IRIN;

    localparam logic [2:0] K_R = 3'd0, K_I = 3'd1, K_LDI = 3'd2, K_LD = 3'd3;
    localparam logic [2:0] K_ST = 3'd4, K_BR = 3'd5, K_NOP = 3'd6;

    typedef struct {
        string       tag;
        logic [20:0] strobes;
        logic        alu_care;
        logic [4:0]  alu;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        con;
        logic [2:0]  kind;
        logic [4:0]  alu;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [20:0] observed();
        return {bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.PCout,
                bus.PCin, bus.IncPC, bus.IRin, bus.MARin, bus.MDRin, bus.MDRout, bus.Yin,
                bus.Zin, bus.Zlowout, bus.Cout, bus.CONin, bus.Read, bus.Write, bus.run};
    endfunction

    // Push the expectation for the coming cycle, then compare at the falling edge
    task automatic step(input string tag, input logic [20:0] s, input logic care,
                        input logic [4:0] alu);
        exp_t e;
        logic [20:0] obs;
        e.tag = tag; e.strobes = s; e.alu_care = care; e.alu = alu;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        obs = observed();
        n_checks++;
        if (obs === e.strobes && (!e.alu_care || bus.alu_op === e.alu))
            n_pass++;
        else
            $display("FAIL %s: got strobes=%b alu_op=%b, want strobes=%b alu_op=%b (care=%0b)",
                     e.tag, obs, bus.alu_op, e.strobes, e.alu, e.alu_care);
    endtask

    task automatic step_run(input string tag, input logic [20:0] s);
        step(tag, s | M_RUN, 1'b0, 5'd0);
    endtask

    task automatic step_alu(input string tag, input logic [20:0] s, input logic [4:0] alu);
        step(tag, s | M_RUN, 1'b1, alu);
    endtask

    task automatic step_zero(input string tag, input logic care);
        step(tag, 21'd0, care, 5'd0);
    endtask

    // IR changes only after T0 is observed so the previous instruction's exit is unaffected
    task automatic exec_vec(input vec_t v);
        step_run({v.name, ":T0"}, W_T0);
        bus.IR  = v.ir;
        bus.CON = v.con;
        step_run({v.name, ":T1"}, W_T1);
        step_run({v.name, ":T2"}, W_T2);
        case (v.kind)
            K_R: begin
                step_run({v.name, ":T3"}, M_GRB | M_ROUT | M_YIN);
                step_alu({v.name, ":T4"}, M_GRC | M_ROUT | M_ZIN, v.alu);
                step_run({v.name, ":T5"}, M_ZLOW | M_GRA | M_RIN);
            end
            K_I: begin
                step_run({v.name, ":T3"}, M_GRB | M_ROUT | M_YIN);
                step_alu({v.name, ":T4"}, M_COUT | M_ZIN, v.alu);
                step_run({v.name, ":T5"}, M_ZLOW | M_GRA | M_RIN);
            end
            K_LDI: begin
                step_run({v.name, ":T3"}, M_GRB | M_BAOUT | M_YIN);
                step_alu({v.name, ":T4"}, M_COUT | M_ZIN, ALU_ADD);
                step_run({v.name, ":T5"}, M_ZLOW | M_GRA | M_RIN);
            end
            K_LD: begin
                step_run({v.name, ":T3"}, M_GRB | M_BAOUT | M_YIN);
                step_alu({v.name, ":T4"}, M_COUT | M_ZIN, ALU_ADD);
                step_run({v.name, ":T5"}, M_ZLOW | M_MARIN);
                step_run({v.name, ":T6"}, M_READ | M_MDRIN);
                step_run({v.name, ":T7"}, M_MDROUT | M_GRA | M_RIN);
            end
            K_ST: begin
                step_run({v.name, ":T3"}, M_GRB | M_BAOUT | M_YIN);
                step_alu({v.name, ":T4"}, M_COUT | M_ZIN, ALU_ADD);
                step_run({v.name, ":T5"}, M_ZLOW | M_MARIN);
                step_run({v.name, ":T6"}, M_GRA | M_ROUT | M_MDRIN);
                step_run({v.name, ":T7"}, M_WRITE);
            end
            K_BR: begin
                step_run({v.name, ":T3"}, M_GRA | M_ROUT | M_CONIN);
                step_run({v.name, ":T4"}, M_PCOUT | M_YIN);
                step_alu({v.name, ":T5"}, M_COUT | M_ZIN, ALU_ADD);
                step_run({v.name, ":T6"}, v.con ? (M_ZLOW | M_PCIN) : 21'd0);
            end
            default: step_run({v.name, ":T3"}, 21'd0);
        endcase
    endtask

    initial begin
        clear        = 1'b0;
        bus.IR       = 32'd0;
        bus.CON      = 1'b0;
        bus.mem_done = 1'b1;

        tbl.push_back('{"add",   32'h18918000, 1'b0, K_R,   ALU_ADD});
        tbl.push_back('{"sub",   32'h20000000, 1'b0, K_R,   ALU_SUB});
        tbl.push_back('{"and",   32'h28000000, 1'b0, K_R,   ALU_AND});
        tbl.push_back('{"or",    32'h30000000, 1'b0, K_R,   ALU_OR});
        tbl.push_back('{"addi",  32'h60000000, 1'b0, K_I,   ALU_ADD});
        tbl.push_back('{"andi",  32'h68000000, 1'b0, K_I,   ALU_AND});
        tbl.push_back('{"ori",   32'h70000000, 1'b0, K_I,   ALU_OR});
        tbl.push_back('{"ldi",   32'h08000000, 1'b0, K_LDI, ALU_ADD});
        tbl.push_back('{"ld",    32'h00900065, 1'b0, K_LD,  ALU_ADD});
        tbl.push_back('{"st",    32'h10000000, 1'b0, K_ST,  ALU_ADD});
        tbl.push_back('{"brx1",  32'h90800010, 1'b1, K_BR,  ALU_ADD});
        tbl.push_back('{"brx0",  32'h90800010, 1'b0, K_BR,  ALU_ADD});
        tbl.push_back('{"nop",   32'hD0000000, 1'b0, K_NOP, ALU_ADD});
        tbl.push_back('{"undef", 32'hF8000000, 1'b0, K_NOP, ALU_ADD});

        step_zero("reset0", 1'b1);
        step_zero("reset1", 1'b1);
        clear = 1'b1;

        for (int i = 0; i < tbl.size(); i++) exec_vec(tbl[i]);

        // clear held low for three edges in the middle of an add
        step_run("rst:T0", W_T0);
        bus.IR = 32'h18918000;
        step_run("rst:T1", W_T1);
        step_run("rst:T2", W_T2);
        step_run("rst:T3", M_GRB | M_ROUT | M_YIN);
        step_alu("rst:T4", M_GRC | M_ROUT | M_ZIN, ALU_ADD);
        clear = 1'b0;
        for (int i = 0; i < 3; i++) step_zero("rst:held", 1'b1);
        clear = 1'b1;

        // ld with three-cycle memory in T6: 10 cycles T0..T0
        step_run("ldw:T0", W_T0);
        bus.IR = 32'h00900065;
        step_run("ldw:T1", W_T1);
        step_run("ldw:T2", W_T2);
        step_run("ldw:T3", M_GRB | M_BAOUT | M_YIN);
        step_alu("ldw:T4", M_COUT | M_ZIN, ALU_ADD);
        step_run("ldw:T5", M_ZLOW | M_MARIN);
        bus.mem_done = 1'b0;
        step_run("ldw:T6a", M_READ | M_MDRIN);
        step_run("ldw:T6b", M_READ | M_MDRIN);
        step_run("ldw:T6c", M_READ | M_MDRIN);
        bus.mem_done = 1'b1;
        step_run("ldw:T7", M_MDROUT | M_GRA | M_RIN);

        // st: fetch waits once in T1, mem_done high in T5/T6, Write waits two cycles
        step_run("stw:T0", W_T0);
        bus.IR = 32'h10000000;
        bus.mem_done = 1'b0;
        step_run("stw:T1a", W_T1);
        step_run("stw:T1b", W_T1);
        bus.mem_done = 1'b1;
        step_run("stw:T2", W_T2);
        step_run("stw:T3", M_GRB | M_BAOUT | M_YIN);
        step_alu("stw:T4", M_COUT | M_ZIN, ALU_ADD);
        step_run("stw:T5", M_ZLOW | M_MARIN);
        step_run("stw:T6", M_GRA | M_ROUT | M_MDRIN);
        bus.mem_done = 1'b0;
        step_run("stw:T7a", M_WRITE);
        step_run("stw:T7b", M_WRITE);
        bus.mem_done = 1'b1;

        // halt parks until clear, ignoring mem_done and CON
        step_run("halt:T0", W_T0);
        bus.IR = 32'hD8000000;
        step_run("halt:T1", W_T1);
        step_run("halt:T2", W_T2);
        step_run("halt:T3", 21'd0);
        for (int i = 0; i < 20; i++) begin
            bus.mem_done = i[0];
            bus.CON      = i[1];
            step_zero("halt:hold", 1'b0);
        end
        bus.mem_done = 1'b1;
        clear = 1'b0;
        step_zero("halt:reset", 1'b1);
        clear = 1'b1;
        step_run("halt:T0after", W_T0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired sequencer for the single-bus datapath. It fetches the instruction, decodes the IR opcode and steps through per-class micro-states. Each cycle it drives the register-select strobes (Gra/Grb/Grc/Rin/Rout/BAout) consumed by the select/encode stage, plus every datapath and memory strobe. It sits directly upstream of the select/encode logic and shares its IR bus.

## Interface
Parameters:
- none; opcodes, ALU op codes and state codes are package constants.

Ports:
- clk  in  1  system clock, rising edge
- clear  in  1  synchronous active-low reset
- IR  in  32  instruction register contents; opcode = IR[31:27]
- CON  in  1  branch condition from CON FF, valid the cycle after CONin
- mem_done  in  1  memory completion for the current Read/Write
- Gra, Grb, Grc  out  1 each  register-field selects to select/encode
- Rin, Rout, BAout  out  1 each  register in/out strobes to select/encode
- PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Yin, Zin, Zlowout, Cout, CONin  out  1 each  datapath strobes
- Read, Write  out  1 each  memory strobes
- alu_op  out  5  ALU operation, meaningful only with Zin
- run  out  1  high while executing; low in RESET and HALT

## Operation
- Moore outputs decoded from the registered state and IR. Every strobe is 0 unless listed for the state.
- clear=0 at any edge: state goes to RESET, all outputs 0, run=0. This aborts any state, including a pending memory wait.
- RESET → T0 on the first edge with clear=1.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin. Hold until mem_done=1, then go to T2.
- T2: MDRout, IRin.
- T3–T7 depend on the opcode class:
  - add 00011, sub 00100, and 00101, or 00110:
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, Zin, alu_op=op.
    - T5: Zlowout, Gra, Rin.
  - addi 01100, andi 01101, ori 01110:
    - T3: as above.
    - T4: Cout, Zin, alu_op=op.
    - T5: as above.
  - ldi 00001:
    - T3: Grb, BAout, Yin.
    - T4: Cout, Zin, alu_op=ADD.
    - T5: Zlowout, Gra, Rin.
  - ld 00000:
    - T3–T4: as ldi.
    - T5: Zlowout, MARin.
    - T6: Read, MDRin. Hold until mem_done.
    - T7: MDRout, Gra, Rin.
  - st 00010:
    - T3–T5: as ld.
    - T6: Gra, Rout, MDRin (Read=0 selects bus).
    - T7: Write. Hold until mem_done.
  - brx 10010:
    - T3: Gra, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, Zin, alu_op=ADD.
    - T6: if CON, Zlowout and PCin; else nothing.
  - nop 11010 and every undefined opcode: T3 with no strobes.
  - halt 11011: T3 → HALT. HALT holds all strobes 0 and run=0 until clear.
- The last state of each class returns to T0.
- Read/Write stay asserted for every cycle of a wait state and drop the cycle after mem_done is sampled.
- mem_done outside T1/T6(ld)/T7(st) is ignored.

## Timing
- Next state is registered. Strobes change only after a rising edge.
- mem_done sampled high in the first wait cycle gives a 1-cycle memory state.
- Instruction lengths with zero-wait memory, counted from the T0 cycle to the next T0:
  - nop: 4 cycles.
  - ALU / ldi: 6 cycles.
  - brx: 7 cycles.
  - ld / st: 8 cycles.
- Each memory wait cycle adds one cycle.
- Reset release: T0 in the second cycle after clear goes high (one RESET cycle).

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_*;
  - alu_op constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR;
  - state enum state_t (RESET, T0–T7, HALT).
- One natural sub-module, opcode_class: combinational IR[31:27] → class (ALU_R, ALU_I, LDI, LD, ST, BR, NOP, HALT).
- The FSM register and output decode live in control_unit.

## Test plan
- Reset: clear=0 for 3 cycles mid-T4 → all outputs 0, run=0. Release clear → RESET one cycle, then T0 with PCout=MARin=IncPC=Zin=1.
- add R1,R2,R3 (IR=0x18918000), mem_done tied 1:
  - T3: Grb·Rout·Yin.
  - T4: Grc·Rout·Zin with alu_op=ALU_ADD.
  - T5: Gra·Rin.
  - T0 again 6 cycles after the first T0.
- ld R1,0x65(R2) (IR=0x00900065), mem_done delayed 3 cycles in T6:
  - T3 BAout=1.
  - Read high exactly 3 cycles in T6, then T7: MDRout·Gra·Rin.
  - 10 cycles total.
- brx (IR=0x90800010):
  - CON=1 → PCin pulses once in T6.
  - CON=0 → no PCin, return to T0.
- st with mem_done asserted during T5 and T6 → ignored; Write still waits for mem_done in T7.
- halt (IR=0xD8000000) → HALT, run=0, stays 20 cycles. clear=0 → RESET.
